rgb_fade_pwm: RTL and testbench

Downstream LED drive stage for the RGB colour sequencer. Accepts 8-bit-per-channel target colours over a valid/ready handshake, ramps each channel's brightness toward the target one step at a time, and drives the three LED pins with glitch-free PWM. Sits between the colour-sequencing logic and the top-level RGB pins. Pin polarity inversion, if any, is done at top level.

---
 rtl/rgb_pkg.sv | 23 ++
 rtl/rgb_pwm_channel.sv | 26 ++
 rtl/rgb_fade_pwm.sv | 112 +++++++++++
 tb/tb_rgb_fade_pwm.sv | 179 +++++++++++++++++
 4 files changed

// File: rtl/rgb_pkg.sv
// Shared types and helpers for the RGB fade/PWM drive stage.
package rgb_pkg;

  localparam int LEVEL_W = 8;
  localparam int NUM_CH  = 3;

  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } rgb_t;

  typedef enum logic {IDLE, FADING} fade_state_t;

  // One fade step: move by 1 toward the target, hold when already there.
  function automatic logic [LEVEL_W-1:0] step_toward(input logic [LEVEL_W-1:0] cur,
                                                     input logic [LEVEL_W-1:0] tgt);
    if (cur < tgt)      return cur + 8'd1;
    else if (cur > tgt) return cur - 8'd1;
    else                return cur;
  endfunction

endpackage

// File: rtl/rgb_pwm_channel.sv
// One LED channel: shadow duty latched at period start, registered compare output.
module rgb_pwm_channel
  import rgb_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic               period_start,
  input  logic [LEVEL_W-1:0] pwm_cnt,
  input  logic [LEVEL_W-1:0] level,
  output logic               pwm_out
);

  logic [LEVEL_W-1:0] duty_q;

  // Duty only changes on the 255->0 edge so a period is never cut short or stretched.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      duty_q  <= '0;
      pwm_out <= 1'b0;
    end else begin
      if (period_start) duty_q <= level;
      pwm_out <= (pwm_cnt < duty_q);
    end
  end

endmodule

// File: rtl/rgb_fade_pwm.sv
// RGB fade engine: accepts target colours, ramps levels one step per interval,
// and drives three PWM channels sharing one period counter.
module rgb_fade_pwm
  import rgb_pkg::*;
#(
  parameter int PWM_DIV       = 4,
  parameter int STEP_INTERVAL = 12000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       color_valid,
  output logic       color_ready,
  input  logic [7:0] color_r,
  input  logic [7:0] color_g,
  input  logic [7:0] color_b,
  output logic       busy,
  output logic       RGB_R,
  output logic       RGB_G,
  output logic       RGB_B
);

  localparam int PW = (PWM_DIV > 1) ? $clog2(PWM_DIV) : 1;
  localparam int SW = (STEP_INTERVAL > 1) ? $clog2(STEP_INTERVAL) : 1;
  localparam logic [PW-1:0] PRE_LAST  = PW'(PWM_DIV - 1);
  localparam logic [SW-1:0] STEP_LAST = SW'(STEP_INTERVAL - 1);

  fade_state_t state_q, state_d;

  rgb_t                              color_in;
  logic [NUM_CH-1:0][LEVEL_W-1:0]    color_vec;
  logic [NUM_CH-1:0][LEVEL_W-1:0]    level_q, target_q, level_step;
  logic [PW-1:0]                     pre_q;
  logic [LEVEL_W-1:0]                pwm_cnt;
  logic [SW-1:0]                     step_q;
  logic                              accept, step_tick, pre_wrap, period_start, at_target;
  logic [NUM_CH-1:0]                 pwm_out;

  assign color_in     = '{r: color_r, g: color_g, b: color_b};
  assign color_vec    = color_in;   // [2]=r, [1]=g, [0]=b
  assign accept       = color_valid && (state_q == IDLE);
  assign step_tick    = (state_q == FADING) && (step_q == STEP_LAST);
  assign pre_wrap     = (pre_q == PRE_LAST);
  assign period_start = pre_wrap && (pwm_cnt == 8'hFF);
  assign at_target    = (level_step == target_q);

  assign color_ready  = (state_q == IDLE);
  assign busy         = (state_q == FADING);
  assign RGB_R        = pwm_out[2];
  assign RGB_G        = pwm_out[1];
  assign RGB_B        = pwm_out[0];

  // Per-channel candidate level for the next step tick.
  always_comb begin
    level_step = level_q;
    for (int i = 0; i < NUM_CH; i++)
      level_step[i] = step_toward(level_q[i], target_q[i]);
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // FSM next state: a colour equal to the current levels never starts a fade.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept && (color_vec != level_q)) state_d = FADING;
      FADING:  if (step_tick && at_target)           state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Targets, step counter and levels; the step counter only runs while fading.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      target_q <= '0;
      level_q  <= '0;
      step_q   <= '0;
    end else if (accept) begin
      target_q <= color_vec;
      step_q   <= '0;
    end else if (state_q == FADING) begin
      step_q <= step_tick ? '0 : step_q + SW'(1);
      if (step_tick) level_q <= level_step;
    end
  end

  // Free-running prescaler and PWM slot counter, independent of the handshake.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pre_q   <= '0;
      pwm_cnt <= '0;
    end else begin
      pre_q <= pre_wrap ? '0 : pre_q + PW'(1);
      if (pre_wrap) pwm_cnt <= pwm_cnt + 8'd1;
    end
  end

  for (genvar ch = 0; ch < NUM_CH; ch++) begin : g_ch
    rgb_pwm_channel u_ch (
      .clk          (clk),
      .rst_n        (rst_n),
      .period_start (period_start),
      .pwm_cnt      (pwm_cnt),
      .level        (level_q[ch]),
      .pwm_out      (pwm_out[ch])
    );
  end

endmodule

// File: tb/tb_rgb_fade_pwm.sv
// Bench for rgb_fade_pwm: cycle-by-cycle comparison of pins/busy/ready against a
// closed-form fade model, plus a duty-accuracy run on a second configuration.
module tb_rgb_fade_pwm;

  localparam int D1  = 1;
  localparam int SI1 = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // primary DUT (PWM_DIV=1, STEP_INTERVAL=4)
  logic       rst_n, c_valid, c_ready, c_busy, R, G, B;
  logic [7:0] c_r, c_g, c_b;

  // duty-accuracy DUT (PWM_DIV=2, STEP_INTERVAL=1)
  logic       rst2_n, v2, ready2, busy2, R2, G2, B2;
  logic [7:0] r2, g2, b2;

  rgb_fade_pwm #(.PWM_DIV(D1), .STEP_INTERVAL(SI1)) dut (
    .clk(clk), .rst_n(rst_n), .color_valid(c_valid), .color_ready(c_ready),
    .color_r(c_r), .color_g(c_g), .color_b(c_b), .busy(c_busy),
    .RGB_R(R), .RGB_G(G), .RGB_B(B));

  rgb_fade_pwm #(.PWM_DIV(2), .STEP_INTERVAL(1)) dut2 (
    .clk(clk), .rst_n(rst2_n), .color_valid(v2), .color_ready(ready2),
    .color_r(r2), .color_g(g2), .color_b(b2), .busy(busy2),
    .RGB_R(R2), .RGB_G(G2), .RGB_B(B2));

  int    n_cmp = 0;
  int    n_bad = 0;
  string phase = "init";

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s/%s: got %0d expected %0d", phase, tag, got, exp);
    end
  endtask

  // ---------------- reference model ----------------
  // Levels follow start + sign*min(floor(edges_since_accept/SI), |target-start|).
  int   e, a, maxd, pwm_prev;
  int   s[3], t[3], duty[3];
  bit   m_ready, m_busy, m_acc;
  logic [2:0] m_out;   // [2]=R [1]=G [0]=B

  function automatic int lvl(input int ch, input int ee);
    int n, d;
    n = (ee > a) ? (ee - a) / SI1 : 0;
    d = t[ch] - s[ch];
    if (d >= 0) return s[ch] + ((n < d) ? n : d);
    else        return s[ch] - ((n < -d) ? n : -d);
  endfunction

  function automatic void model_reset();
    e = 0; a = 0; maxd = 0; pwm_prev = 0;
    for (int ch = 0; ch < 3; ch++) begin s[ch] = 0; t[ch] = 0; duty[ch] = 0; end
    m_ready = 1'b1; m_busy = 1'b0; m_out = 3'b000;
  endfunction

  function automatic void model_edge(input int nr, input int ng, input int nb);
    int col[3];
    col[2] = nr; col[1] = ng; col[0] = nb;
    for (int ch = 0; ch < 3; ch++) m_out[ch] = (pwm_prev < duty[ch]);
    e++;
    if (e % (256 * D1) == 0)
      for (int ch = 0; ch < 3; ch++) duty[ch] = lvl(ch, e - 1);
    pwm_prev = (e / D1) % 256;
    if (m_acc) begin
      maxd = 0;
      for (int ch = 0; ch < 3; ch++) begin
        s[ch] = lvl(ch, e - 1);
        t[ch] = col[ch];
        if ((t[ch] - s[ch]) > maxd) maxd = t[ch] - s[ch];
        if ((s[ch] - t[ch]) > maxd) maxd = s[ch] - t[ch];
      end
      a = e;
    end
    m_busy  = (e - a) < maxd * SI1;
    m_ready = !m_busy;
  endfunction

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    m_acc = c_valid && m_ready;
    @(posedge clk);
    model_edge(c_r, c_g, c_b);
    @(negedge clk);
    chk("rgb",   {29'd0, R, G, B}, {29'd0, m_out});
    chk("busy",  {31'd0, c_busy},  {31'd0, m_busy});
    chk("ready", {31'd0, c_ready}, {31'd0, m_ready});
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  // Offer a colour and hold it until taken; an expired bound counts as a failure.
  task automatic send(input int r, input int g, input int b);
    int  n;
    bit  got;
    n = 0; got = 1'b0;
    c_r = 8'(r); c_g = 8'(g); c_b = 8'(b); c_valid = 1'b1;
    while (!got && n < 5000) begin
      tick();
      got = m_acc;
      n++;
    end
    c_valid = 1'b0;
    chk("accept_in_bound", {31'd0, got}, 32'd1);
  endtask

  task automatic do_reset(input int cyc);
    rst_n = 1'b0; c_valid = 1'b0;
    repeat (cyc) @(posedge clk);
    @(negedge clk);
    model_reset();
    chk("rst.rgb",   {29'd0, R, G, B}, {29'd0, m_out});
    chk("rst.busy",  {31'd0, c_busy},  {31'd0, m_busy});
    chk("rst.ready", {31'd0, c_ready}, {31'd0, m_ready});
    rst_n = 1'b1;
  endtask

  initial begin
    int nc[3];
    int hr, hg, hb;
    rst_n = 1'b0; c_valid = 1'b0; c_r = '0; c_g = '0; c_b = '0;
    rst2_n = 1'b0; v2 = 1'b0; r2 = '0; g2 = '0; b2 = '0;
    model_reset();

    phase = "reset";      do_reset(3);
    phase = "noop";       send(0, 0, 0); run(20);
    phase = "fade_up";    send(3, 0, 0);
    phase = "backpress";  send(9, 9, 9); run(600);
    phase = "to_ten";     send(10, 10, 10); run(100);
    phase = "fade_down";  send(8, 12, 10); run(600);
    phase = "mid_reset";  send(200, 0, 50); run(50); do_reset(3); run(300);

    phase = "random";
    for (int k = 0; k < 25; k++) begin
      for (int ch = 0; ch < 3; ch++) begin
        nc[ch] = t[ch];
        if ($urandom_range(0, 3) != 0) begin
          nc[ch] = t[ch] + int'($urandom_range(0, 40)) - 20;
          if (nc[ch] < 0)   nc[ch] = 0;
          if (nc[ch] > 255) nc[ch] = 255;
        end
      end
      if ($urandom_range(0, 1) == 1) run($urandom_range(0, 120));
      send(nc[2], nc[1], nc[0]);
    end
    run(700);

    // Duty accuracy on the second configuration: 512-cycle period.
    phase = "duty";
    rst2_n = 1'b1;
    @(negedge clk);
    r2 = 8'd255; g2 = 8'd128; b2 = 8'd0; v2 = 1'b1;
    @(negedge clk);
    v2 = 1'b0;
    chk("busy_after_accept", {31'd0, busy2}, 32'd1);
    repeat (1600) @(negedge clk);
    chk("busy_settled",  {31'd0, busy2},  32'd0);
    chk("ready_settled", {31'd0, ready2}, 32'd1);
    hr = 0; hg = 0; hb = 0;
    for (int i = 0; i < 512; i++) begin
      @(negedge clk);
      hr += int'(R2); hg += int'(G2); hb += int'(B2);
    end
    chk("R_high", hr, 510);
    chk("G_high", hg, 256);
    chk("B_high", hb, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
